pool_max: RTL and testbench
===========================

Name: pool_max

Overview:
- Max-pooling stage placed directly downstream of the normalization block.
- Consumes one DESIGN_SIZE-lane column per valid cycle from the norm output and computes a per-lane signed maximum over a window of consecutive columns.
- Emits one pooled column per window to the activation stage.
- When disabled, it is a one-cycle registered pass-through.

Parameters:
- DWIDTH, 8, lane width in bits (signed two's complement).
- DESIGN_SIZE, 16, lanes per column and columns per tile.
- MAX_BITS_POOL, 3, width of the pool window select.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_pool  in  1  1 = pool, 0 = bypass.
- pool_window_size  in  MAX_BITS_POOL  window in columns; legal values 1, 2, 4; any other value is treated as 1.
- in_data_available  in  1  input column valid this cycle.
- inp_data  in  DESIGN_SIZE*DWIDTH  input column; lane i at [i*DWIDTH +: DWIDTH].
- validity_mask  in  DESIGN_SIZE  1 = lane active.
- out_data  out  DESIGN_SIZE*DWIDTH  pooled column.
- out_data_available  out  1  single-cycle strobe qualifying out_data.
- done_pool  out  1  tile complete.

Behaviour:
- Reset asserted (low), asynchronously: state=IDLE, all counters 0, lane accumulators 0, out_data=0, out_data_available=0, done_pool_internal=0, bypass flops 0.
- Bypass, enable_pool=0:
  - out_data = inp_data registered one cycle; out_data_available = in_data_available registered one cycle; done_pool = 1 (combinational).
  - The FSM is held in IDLE with counters and accumulators cleared.
  - Bypass flops update every cycle regardless of FSM state.
- Pooling mode, enable_pool=1:
  - The output muxes select FSM outputs; done_pool = done_pool_internal.
  - win_len = 1, 2 or 4, sampled from pool_window_size on the first valid column of the tile and held until DONE.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: on in_data_available=1, load the accumulators with the column, set col_cnt=1, win_cnt=1, go to ACCUM. If win_len=1, the output strobe fires on the following cycle.
  - ACCUM: each cycle with in_data_available=1, for each lane compare the input with acc (signed) and keep the larger. col_cnt and win_cnt increment. Cycles with in_data_available=0 are gaps: no state change.
  - When win_cnt reaches win_len on a valid cycle:
    - The final max (including the current column) is registered into out_data, and out_data_available pulses 1 on the next cycle.
    - win_cnt returns to 0.
    - The next valid column loads acc directly; no comparison against the stale value.
  - When col_cnt reaches DESIGN_SIZE on a valid cycle: go to DONE after emitting the last window. DESIGN_SIZE is a multiple of every legal win_len, so no partial window exists.
  - DONE: done_pool_internal=1 and held; in_data_available is ignored. Leave to IDLE only when enable_pool deasserts.
- Masked lanes: validity_mask[i]=0 forces out_data lane i to 0 in the emitted column; that lane's accumulator is don't-care. The mask is sampled on each valid cycle; a lane contributes to a window only if its mask bit is 1 on the window's final column.
- Latency: the output strobe comes 1 cycle after the valid cycle carrying the window's last column. Throughput is one input column per cycle with no stalls.
- out_data holds its last pooled value between strobes. out_data_available is 0 except for the strobe cycle.
- Comparisons are signed, full DWIDTH. No arithmetic widening and no saturation are needed.
- enable_pool dropping mid-tile: the FSM clears to IDLE on the next edge and the partial window is discarded.
- Reset mid-tile: immediate clear. No output strobe for the partial window.
- pool_window_size changing mid-tile: ignored until the next tile.

Test Plan:
1. Reset/bypass: enable_pool=0, inp_data lane0=0x05, in_data_available=1 for 1 cycle -> next cycle out_data lane0=0x05, out_data_available=1, done_pool=1. Assert reset low mid-cycle -> outputs 0 immediately.
2. Window 2, signed: lane0 gets columns 0x7F, 0x80, 0xFE, 0x01, ... -> first strobe lane0=0x7F, second strobe lane0=0x01. 8 strobes total, then done_pool=1 one cycle after the 8th strobe's input column.
3. Window 4 with gaps: 16 columns with in_data_available toggling 1/0, all lanes = column index -> strobes carry 3, 7, 11, 15 in every lane. Exactly 4 strobes. Idle cycles produce no strobe.
4. Window 1 and illegal window 3: both produce 16 strobes. Each out_data equals its input column, delayed 1 cycle.
5. Mask: validity_mask=0xFFFE, window 2, lane0 inputs 0x10/0x20 -> lane0 output 0x00, lane1 output max as normal.
6. Abort: window 4, drop enable_pool after 6 columns -> no strobe for the partial window. Re-enable and start a new tile -> the first strobe reflects only new columns, and done_pool asserts after 16 new columns.

Source files
------------

// File: rtl/pool_max.sv
// pool_max: per-lane signed max pooling over windows of 1, 2 or 4 consecutive
// columns, with a one-cycle registered bypass when pooling is disabled.
module pool_max #(
  parameter int DWIDTH        = 8,
  parameter int DESIGN_SIZE   = 16,
  parameter int MAX_BITS_POOL = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_pool,
  input  logic [MAX_BITS_POOL-1:0]      pool_window_size,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  input  logic [DESIGN_SIZE-1:0]        validity_mask,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic                          out_data_available,
  output logic                          done_pool
);

  localparam int CW = $clog2(DESIGN_SIZE + 1);
  localparam int DW = DESIGN_SIZE * DWIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   col_cnt, col_cnt_next;
  logic [2:0]      win_cnt, win_cnt_next;
  logic [2:0]      win_len, win_len_next;
  logic [DW-1:0]   acc, acc_next;
  logic [DW-1:0]   pool_data, pool_data_next;
  logic            pool_avail, pool_avail_next;
  logic            done_int, done_int_next;

  logic [DW-1:0]   byp_data;
  logic            byp_avail;

  logic [2:0]      win_sel;
  logic [2:0]      eff_len;
  logic            first_col;
  logic [CW-1:0]   col_step;
  logic [2:0]      win_step;
  logic [DW-1:0]   col_max;
  logic [DW-1:0]   masked_max;

  // Decode the requested window; anything other than 2 or 4 behaves as 1.
  always_comb begin
    win_sel = 3'd1;
    if (pool_window_size == MAX_BITS_POOL'(2))
      win_sel = 3'd2;
    else if (pool_window_size == MAX_BITS_POOL'(4))
      win_sel = 3'd4;
  end

  // In IDLE the tile has not latched its window yet, so use the live decode.
  assign eff_len   = (state == IDLE) ? win_sel : win_len;
  assign first_col = (state == IDLE) || (win_cnt == 3'd0);
  assign col_step  = (state == IDLE) ? CW'(1) : col_cnt + CW'(1);
  assign win_step  = (state == IDLE) ? 3'd1 : win_cnt + 3'd1;

  // Per-lane running max; the first column of a window loads directly.
  always_comb begin
    col_max    = '0;
    masked_max = '0;
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      if (first_col ||
          ($signed(inp_data[i*DWIDTH +: DWIDTH]) > $signed(acc[i*DWIDTH +: DWIDTH])))
        col_max[i*DWIDTH +: DWIDTH] = inp_data[i*DWIDTH +: DWIDTH];
      else
        col_max[i*DWIDTH +: DWIDTH] = acc[i*DWIDTH +: DWIDTH];
      masked_max[i*DWIDTH +: DWIDTH] = validity_mask[i] ? col_max[i*DWIDTH +: DWIDTH]
                                                        : {DWIDTH{1'b0}};
    end
  end

  // Next-state and datapath updates for the pooling FSM.
  always_comb begin
    state_next      = state;
    col_cnt_next    = col_cnt;
    win_cnt_next    = win_cnt;
    win_len_next    = win_len;
    acc_next        = acc;
    pool_data_next  = pool_data;
    pool_avail_next = 1'b0;
    done_int_next   = done_int;

    if (!enable_pool) begin
      state_next    = IDLE;
      col_cnt_next  = '0;
      win_cnt_next  = 3'd0;
      win_len_next  = 3'd0;
      acc_next      = '0;
      done_int_next = 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_data_available) begin
            acc_next     = col_max;
            col_cnt_next = col_step;
            if (state == IDLE)
              win_len_next = win_sel;
            if (win_step == eff_len) begin
              pool_data_next  = masked_max;
              pool_avail_next = 1'b1;
              win_cnt_next    = 3'd0;
            end else begin
              win_cnt_next = win_step;
            end
            if (col_step == CW'(DESIGN_SIZE)) begin
              state_next    = DONE;
              done_int_next = 1'b1;
            end else begin
              state_next = ACCUM;
            end
          end
        end
        DONE: begin
          done_int_next = 1'b1;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Pooling state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      col_cnt    <= '0;
      win_cnt    <= 3'd0;
      win_len    <= 3'd0;
      acc        <= '0;
      pool_data  <= '0;
      pool_avail <= 1'b0;
      done_int   <= 1'b0;
    end else begin
      state      <= state_next;
      col_cnt    <= col_cnt_next;
      win_cnt    <= win_cnt_next;
      win_len    <= win_len_next;
      acc        <= acc_next;
      pool_data  <= pool_data_next;
      pool_avail <= pool_avail_next;
      done_int   <= done_int_next;
    end
  end

  // Bypass path runs every cycle so switching modes never exposes stale data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_data  <= '0;
      byp_avail <= 1'b0;
    end else begin
      byp_data  <= inp_data;
      byp_avail <= in_data_available;
    end
  end

  assign out_data           = enable_pool ? pool_data  : byp_data;
  assign out_data_available = enable_pool ? pool_avail : byp_avail;
  assign done_pool          = enable_pool ? done_int   : 1'b1;

endmodule

// File: tb/tb_pool_max.sv
// tb_pool_max: directed scoreboard bench for pool_max.
module tb_pool_max;

  localparam int DS = 16;
  localparam int DWD = 8;
  localparam int W = DS * DWD;

  logic          clk;
  logic          reset;
  logic          enable_pool;
  logic [2:0]    pool_window_size;
  logic          in_data_available;
  logic [W-1:0]  inp_data;
  logic [DS-1:0] validity_mask;
  logic [W-1:0]  out_data;
  logic          out_data_available;
  logic          done_pool;

  logic [W-1:0]  sb[$];
  logic [W-1:0]  obs[$];
  int            test_cnt = 0;
  int            fail_cnt = 0;
  int            strobe_cnt = 0;

  int            m_len, m_cnt, m_col;
  bit            m_done;
  logic [W-1:0]  m_acc;

  pool_max dut (
    .clk                (clk),
    .reset              (reset),
    .enable_pool        (enable_pool),
    .pool_window_size   (pool_window_size),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_pool          (done_pool)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int legal_len(input logic [2:0] s);
    if (s == 3'd2) return 2;
    if (s == 3'd4) return 4;
    return 1;
  endfunction

  function automatic logic [7:0] lane(input logic [W-1:0] c, input int i);
    return c[i*DWD +: DWD];
  endfunction

  function automatic logic [W-1:0] fill(input logic [7:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DS; i++) r[i*DWD +: DWD] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_col();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    test_cnt++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    m_cnt  = 0;
    m_col  = 0;
    m_done = 0;
    m_acc  = '0;
  endtask

  // Drive one cycle of input and predict any resulting output column.
  task automatic applyStimulus(input logic [W-1:0] col, input logic valid);
    logic signed [7:0] a;
    logic signed [7:0] c;
    logic [W-1:0]      exp;
    @(posedge clk);
    #1;
    inp_data          = col;
    in_data_available = valid;
    if (valid) begin
      if (!enable_pool) begin
        sb.push_back(col);
      end else if (!m_done) begin
        if (m_col == 0) m_len = legal_len(pool_window_size);
        for (int i = 0; i < DS; i++) begin
          a = m_acc[i*DWD +: DWD];
          c = col[i*DWD +: DWD];
          if (m_cnt == 0 || c > a) m_acc[i*DWD +: DWD] = c;
        end
        m_cnt++;
        m_col++;
        if (m_cnt == m_len) begin
          exp = '0;
          for (int i = 0; i < DS; i++)
            if (validity_mask[i]) exp[i*DWD +: DWD] = m_acc[i*DWD +: DWD];
          sb.push_back(exp);
          m_cnt = 0;
        end
        if (m_col == DS) m_done = 1;
      end
    end
  endtask

  task automatic setEnable(input logic v);
    @(posedge clk);
    #1;
    enable_pool       = v;
    in_data_available = 1'b0;
    resetModel();
  endtask

  // Every strobe must match the oldest predicted column.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_data_available === 1'b1) begin
      strobe_cnt++;
      obs.push_back(out_data);
      test_cnt++;
      assert (sb.size() != 0) else begin
        fail_cnt++;
        $error("[TB] FAIL unexpected_strobe: observed %h expected no strobe", out_data);
      end
      if (sb.size() != 0) checkOutput("strobe_data", out_data, sb.pop_front());
    end
  end

  // Hard bound on simulation time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int s0;
    logic [W-1:0] col;

    reset             = 1'b0;
    enable_pool       = 1'b0;
    pool_window_size  = 3'd1;
    in_data_available = 1'b0;
    inp_data          = '0;
    validity_mask     = '1;
    resetModel();

    // Reset state in both modes.
    #22;
    checkOutput("reset_out_data", out_data, '0);
    checkOutput("reset_avail", W'(out_data_available), W'(0));
    checkOutput("reset_bypass_done", W'(done_pool), W'(1));
    enable_pool = 1'b1;
    #1;
    checkOutput("reset_pool_done", W'(done_pool), W'(0));
    enable_pool = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Bypass pass-through, then asynchronous reset mid-cycle.
    $display("[TB] bypass");
    col = '0;
    col[7:0] = 8'h05;
    applyStimulus(col, 1'b1);
    applyStimulus('0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("bypass_lane0", W'(lane(out_data, 0)), W'(8'h05));
    checkOutput("bypass_avail", W'(out_data_available), W'(1));
    checkOutput("bypass_done", W'(done_pool), W'(1));
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_data", out_data, '0);
    checkOutput("async_reset_avail", W'(out_data_available), W'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Window 2 with signed extremes in lane 0.
    $display("[TB] window 2 signed");
    pool_window_size = 3'd2;
    setEnable(1'b1);
    base = obs.size();
    s0   = strobe_cnt;
    for (int k = 0; k < DS; k++) begin
      col = rand_col();
      case (k)
        0: col[7:0] = 8'h7F;
        1: col[7:0] = 8'h80;
        2: col[7:0] = 8'hFE;
        3: col[7:0] = 8'h01;
        default: ;
      endcase
      applyStimulus(col, 1'b1);
      if (k == DS - 1) checkOutput("done_before_last", W'(done_pool), W'(0));
    end
    applyStimulus(rand_col(), 1'b1);
    checkOutput("done_after_last", W'(done_pool), W'(1));
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("w2_strobes", W'(strobe_cnt - s0), W'(8));
    checkOutput("w2_first_lane0", W'(lane(obs[base], 0)), W'(8'h7F));
    checkOutput("w2_second_lane0", W'(lane(obs[base+1], 0)), W'(8'h01));
    checkOutput("w2_done_held", W'(done_pool), W'(1));
    setEnable(1'b0);

    // Window 4 with a gap after every column.
    $display("[TB] window 4 gaps");
    pool_window_size = 3'd4;
    setEnable(1'b1);
    base = obs.size();
    s0   = strobe_cnt;
    for (int k = 0; k < DS; k++) begin
      applyStimulus(fill(8'(k)), 1'b1);
      applyStimulus(fill(8'(k)), 1'b0);
    end
    applyStimulus('0, 1'b0);
    checkOutput("w4_strobes", W'(strobe_cnt - s0), W'(4));
    for (int j = 0; j < 4; j++)
      checkOutput("w4_value", obs[base+j], fill(8'(4*j + 3)));
    checkOutput("w4_done", W'(done_pool), W'(1));
    setEnable(1'b0);

    // Window 1 and the illegal window 3 both pass every column.
    for (int p = 0; p < 2; p++) begin
      $display("[TB] window %0d", (p == 0) ? 1 : 3);
      pool_window_size = (p == 0) ? 3'd1 : 3'd3;
      setEnable(1'b1);
      s0 = strobe_cnt;
      for (int k = 0; k < DS; k++) applyStimulus(rand_col(), 1'b1);
      applyStimulus('0, 1'b0);
      applyStimulus('0, 1'b0);
      checkOutput("w1_strobes", W'(strobe_cnt - s0), W'(16));
      checkOutput("w1_done", W'(done_pool), W'(1));
      setEnable(1'b0);
    end

    // Masked lane 0 is forced to zero.
    $display("[TB] mask");
    pool_window_size = 3'd2;
    validity_mask    = 16'hFFFE;
    setEnable(1'b1);
    base = obs.size();
    s0   = strobe_cnt;
    for (int k = 0; k < DS; k++) begin
      col = rand_col();
      col[7:0]  = (k % 2 == 0) ? 8'h10 : 8'h20;
      col[15:8] = (k % 2 == 0) ? 8'h05 : 8'hF0;
      applyStimulus(col, 1'b1);
    end
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("mask_strobes", W'(strobe_cnt - s0), W'(8));
    checkOutput("mask_lane0", W'(lane(obs[base], 0)), W'(8'h00));
    checkOutput("mask_lane1", W'(lane(obs[base], 1)), W'(8'h05));
    setEnable(1'b0);
    validity_mask = '1;

    // Abort a window-4 tile after 6 columns, then run a fresh tile.
    $display("[TB] abort");
    pool_window_size = 3'd4;
    setEnable(1'b1);
    s0 = strobe_cnt;
    for (int k = 0; k < 6; k++) applyStimulus(fill(8'h70), 1'b1);
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    setEnable(1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("abort_strobes", W'(strobe_cnt - s0), W'(1));
    setEnable(1'b1);
    base = obs.size();
    s0   = strobe_cnt;
    for (int k = 0; k < DS; k++) begin
      if (k == 2) pool_window_size = 3'd1;
      applyStimulus(fill(8'(k)), 1'b1);
      if (k == 8) checkOutput("retile_done_mid", W'(done_pool), W'(0));
    end
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("retile_strobes", W'(strobe_cnt - s0), W'(4));
    checkOutput("retile_first", W'(lane(obs[base], 0)), W'(8'h03));
    checkOutput("retile_done", W'(done_pool), W'(1));
    checkOutput("scoreboard_empty", W'(sb.size()), W'(0));
    setEnable(1'b0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
